// File: rtl/mix_sequencer.sv
// Time-multiplexed voice mixer: fetches each unmuted voice, scales it by its
// envelope on a shared multiplier, splits it onto filter/bypass buses, runs the
// external filter, applies master volume and emits one audio sample per frame.
module mix_sequencer #(
  parameter int unsigned NUM_VOICES = 3,
  parameter int unsigned WAVE_W     = 10,
  parameter int unsigned ENV_W      = 8,
  parameter int unsigned ACC_W      = 14,
  parameter int unsigned VOL_W      = 8,
  parameter int unsigned MULT_A_W   = 24,
  parameter int unsigned MULT_B_W   = 16,
  localparam int unsigned IDX_W     = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1,
  localparam int unsigned PROD_W    = MULT_A_W + MULT_B_W
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     sample_tick_i,
  output logic                     voice_req_o,
  output logic [IDX_W-1:0]         voice_idx_o,
  input  logic                     voice_ack_i,
  input  logic signed [WAVE_W-1:0] voice_wave_i,
  input  logic [ENV_W-1:0]         env_i,
  input  logic [NUM_VOICES-1:0]    mute_i,
  input  logic [NUM_VOICES-1:0]    filt_route_i,
  output logic                     mult_start_o,
  output logic [MULT_A_W-1:0]      mult_a_o,
  output logic [MULT_B_W-1:0]      mult_b_o,
  input  logic                     mult_ready_i,
  input  logic signed [PROD_W-1:0] mult_prod_i,
  output logic                     filt_start_o,
  output logic [ACC_W-1:0]         filt_in_o,
  input  logic                     filt_ready_i,
  input  logic signed [ACC_W-1:0]  filt_out_i,
  input  logic [VOL_W-1:0]         volume_i,
  output logic signed [ACC_W-1:0]  audio_o,
  output logic                     audio_valid_o,
  output logic                     overrun_o
);

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_VMUL, S_NEXT, S_FILT, S_VOL, S_DONE} state_t;

  // Clamp a wide signed value into the accumulator range.
  function automatic logic [ACC_W-1:0] sat_acc(input logic [PROD_W-1:0] v);
    logic [PROD_W-ACC_W:0] top;
    top = v[PROD_W-1:ACC_W-1];
    if ((&top) || !(|top)) return v[ACC_W-1:0];
    return v[PROD_W-1] ? ACC_MIN : ACC_MAX;
  endfunction

  // Saturating add of two accumulator-width values.
  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (s[ACC_W] != s[ACC_W-1]) return s[ACC_W] ? ACC_MIN : ACC_MAX;
    return s[ACC_W-1:0];
  endfunction

  // Lowest unmuted voice at or above 'from'; MSB flags whether one exists.
  function automatic logic [IDX_W:0] find_voice(input logic [NUM_VOICES-1:0] mute, input int from);
    logic             found;
    logic [IDX_W-1:0] idx;
    found = 1'b0;
    idx   = '0;
    for (int i = int'(NUM_VOICES) - 1; i >= 0; i--) begin
      if (i >= from && !mute[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
    return {found, idx};
  endfunction

  state_t                r_state, w_state_n;
  logic [IDX_W-1:0]      r_idx, w_idx_n;
  logic                  r_voice_req, w_voice_req_n;
  logic                  r_mult_start, w_mult_start_n;
  logic [MULT_A_W-1:0]   r_mult_a, w_mult_a_n;
  logic [MULT_B_W-1:0]   r_mult_b, w_mult_b_n;
  logic                  r_filt_start, w_filt_start_n;
  logic [ACC_W-1:0]      r_filt_in, w_filt_in_n;
  logic [ACC_W-1:0]      r_filt_acc, w_filt_acc_n;
  logic [ACC_W-1:0]      r_byp_acc, w_byp_acc_n;
  logic                  r_route_cur, w_route_cur_n;
  logic                  r_route_any, w_route_any_n;
  logic [ACC_W-1:0]      r_audio, w_audio_n;
  logic                  r_audio_valid, w_audio_valid_n;
  logic                  r_overrun, w_overrun_n;

  logic [IDX_W:0]        w_first, w_next;
  logic [ACC_W-1:0]      w_term, w_vol_prod, w_mix;

  assign w_first    = find_voice(mute_i, 0);
  assign w_next     = find_voice(mute_i, int'(r_idx) + 1);
  assign w_term     = sat_acc(mult_prod_i >>> ENV_W);
  assign w_vol_prod = sat_acc(mult_prod_i >>> VOL_W);
  assign w_mix      = sat_add(filt_out_i, r_byp_acc);

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_voice_req   <= 1'b0;
      r_mult_start  <= 1'b0;
      r_mult_a      <= '0;
      r_mult_b      <= '0;
      r_filt_start  <= 1'b0;
      r_filt_in     <= '0;
      r_filt_acc    <= '0;
      r_byp_acc     <= '0;
      r_route_cur   <= 1'b0;
      r_route_any   <= 1'b0;
      r_audio       <= '0;
      r_audio_valid <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_state       <= w_state_n;
      r_idx         <= w_idx_n;
      r_voice_req   <= w_voice_req_n;
      r_mult_start  <= w_mult_start_n;
      r_mult_a      <= w_mult_a_n;
      r_mult_b      <= w_mult_b_n;
      r_filt_start  <= w_filt_start_n;
      r_filt_in     <= w_filt_in_n;
      r_filt_acc    <= w_filt_acc_n;
      r_byp_acc     <= w_byp_acc_n;
      r_route_cur   <= w_route_cur_n;
      r_route_any   <= w_route_any_n;
      r_audio       <= w_audio_n;
      r_audio_valid <= w_audio_valid_n;
      r_overrun     <= w_overrun_n;
    end
  end

  // Next-state and next-output logic; strobes default low so they pulse once.
  always_comb begin
    w_state_n       = r_state;
    w_idx_n         = r_idx;
    w_voice_req_n   = r_voice_req;
    w_mult_start_n  = 1'b0;
    w_mult_a_n      = r_mult_a;
    w_mult_b_n      = r_mult_b;
    w_filt_start_n  = 1'b0;
    w_filt_in_n     = r_filt_in;
    w_filt_acc_n    = r_filt_acc;
    w_byp_acc_n     = r_byp_acc;
    w_route_cur_n   = r_route_cur;
    w_route_any_n   = r_route_any;
    w_audio_n       = r_audio;
    w_audio_valid_n = 1'b0;
    w_overrun_n     = r_overrun | (sample_tick_i && (r_state != S_IDLE));

    case (r_state)
      S_IDLE: begin
        if (sample_tick_i) begin
          w_filt_acc_n  = '0;
          w_byp_acc_n   = '0;
          w_route_any_n = 1'b0;
          if (w_first[IDX_W]) begin
            w_idx_n       = w_first[IDX_W-1:0];
            w_voice_req_n = 1'b1;
            w_state_n     = S_FETCH;
          end else begin
            w_state_n     = S_FILT;
          end
        end
      end
      S_FETCH: begin
        if (voice_ack_i) begin
          w_voice_req_n  = 1'b0;
          w_route_cur_n  = filt_route_i[r_idx];
          w_mult_start_n = 1'b1;
          w_mult_a_n     = {{(MULT_A_W-WAVE_W){voice_wave_i[WAVE_W-1]}}, voice_wave_i};
          w_mult_b_n     = {{(MULT_B_W-ENV_W){1'b0}}, env_i};
          w_state_n      = S_VMUL;
        end
      end
      S_VMUL: begin
        if (mult_ready_i) begin
          w_mult_a_n = '0;
          w_mult_b_n = '0;
          if (r_route_cur) begin
            w_filt_acc_n  = sat_add(r_filt_acc, w_term);
            w_route_any_n = 1'b1;
          end else begin
            w_byp_acc_n   = sat_add(r_byp_acc, w_term);
          end
          w_state_n = S_NEXT;
        end
      end
      S_NEXT: begin
        if (w_next[IDX_W]) begin
          w_idx_n       = w_next[IDX_W-1:0];
          w_voice_req_n = 1'b1;
          w_state_n     = S_FETCH;
        end else begin
          w_filt_start_n = r_route_any;
          w_filt_in_n    = r_route_any ? r_filt_acc : '0;
          w_state_n      = S_FILT;
        end
      end
      S_FILT: begin
        // Filter skipped entirely when nothing was routed to it.
        if (!r_route_any || filt_ready_i) begin
          w_filt_in_n    = '0;
          w_mult_start_n = 1'b1;
          w_mult_a_n     = r_route_any ? {{(MULT_A_W-ACC_W){w_mix[ACC_W-1]}}, w_mix}
                                       : {{(MULT_A_W-ACC_W){r_byp_acc[ACC_W-1]}}, r_byp_acc};
          w_mult_b_n     = {{(MULT_B_W-VOL_W){1'b0}}, volume_i};
          w_state_n      = S_VOL;
        end
      end
      S_VOL: begin
        if (mult_ready_i) begin
          w_mult_a_n      = '0;
          w_mult_b_n      = '0;
          w_audio_n       = w_vol_prod;
          w_audio_valid_n = 1'b1;
          w_state_n       = S_DONE;
        end
      end
      S_DONE: begin
        w_state_n = S_IDLE;
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  assign voice_req_o   = r_voice_req;
  assign voice_idx_o   = r_idx;
  assign mult_start_o  = r_mult_start;
  assign mult_a_o      = r_mult_a;
  assign mult_b_o      = r_mult_b;
  assign filt_start_o  = r_filt_start;
  assign filt_in_o     = r_filt_in;
  assign audio_o       = r_audio;
  assign audio_valid_o = r_audio_valid;
  assign overrun_o     = r_overrun;

endmodule

// File: tb/tb_mix_sequencer.sv
// Bench for mix_sequencer: two instances (ACC_W 14 and 10) run in lockstep
// against multiplier/filter/voice models; audio and filter inputs are checked
// by a scoreboard monitor, plus handshake protocol checks every cycle.
module tb_mix_sequencer;

  localparam int PW = 40;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              tick, voice_ack, mult_ready, filt_ready;
  logic signed [9:0] voice_wave;
  logic [7:0]        env, volume;
  logic [2:0]        mute, route;

  logic              req_a, req_b, mstart_a, mstart_b, fstart_a, fstart_b;
  logic [1:0]        idx_a, idx_b;
  logic [23:0]       ma_a, ma_b;
  logic [15:0]       mb_a, mb_b;
  logic [13:0]       fin_a;
  logic [9:0]        fin_b;
  logic signed [13:0] audio_a, fout_a;
  logic signed [9:0]  audio_b, fout_b;
  logic              aval_a, aval_b, ovr_a, ovr_b;
  logic signed [PW-1:0] prod_a, prod_b;

  int checks = 0;
  int errors = 0;
  int nval_a = 0;
  int qa[$], qb[$], qf[$];

  logic signed [9:0] w_tab[4];
  logic [7:0]        e_tab[4];
  assign voice_wave = w_tab[idx_a];
  assign env        = e_tab[idx_a];

  mix_sequencer #(.ACC_W(14)) u_a (
    .clk_i(clk), .rst_i(rst), .sample_tick_i(tick), .voice_req_o(req_a), .voice_idx_o(idx_a),
    .voice_ack_i(voice_ack), .voice_wave_i(voice_wave), .env_i(env), .mute_i(mute),
    .filt_route_i(route), .mult_start_o(mstart_a), .mult_a_o(ma_a), .mult_b_o(mb_a),
    .mult_ready_i(mult_ready), .mult_prod_i(prod_a), .filt_start_o(fstart_a), .filt_in_o(fin_a),
    .filt_ready_i(filt_ready), .filt_out_i(fout_a), .volume_i(volume), .audio_o(audio_a),
    .audio_valid_o(aval_a), .overrun_o(ovr_a));

  mix_sequencer #(.ACC_W(10)) u_b (
    .clk_i(clk), .rst_i(rst), .sample_tick_i(tick), .voice_req_o(req_b), .voice_idx_o(idx_b),
    .voice_ack_i(voice_ack), .voice_wave_i(voice_wave), .env_i(env), .mute_i(mute),
    .filt_route_i(route), .mult_start_o(mstart_b), .mult_a_o(ma_b), .mult_b_o(mb_b),
    .mult_ready_i(mult_ready), .mult_prod_i(prod_b), .filt_start_o(fstart_b), .filt_in_o(fin_b),
    .filt_ready_i(filt_ready), .filt_out_i(fout_b), .volume_i(volume), .audio_o(audio_b),
    .audio_valid_o(aval_b), .overrun_o(ovr_b));

  // Voice source: acknowledges after a fixed or random latency, or never when held.
  int ack_cnt;
  bit ack_rand = 1'b0;
  bit ack_hold = 1'b0;
  assign voice_ack = req_a && !ack_hold && (ack_cnt == 0);
  always @(posedge clk or posedge rst) begin
    if (rst) ack_cnt <= 0;
    else if (!req_a || voice_ack) ack_cnt <= ack_rand ? int'($urandom_range(0, 4)) : 0;
    else if (ack_cnt > 0) ack_cnt <= ack_cnt - 1;
  end

  // Shared multiplier: ready mult_dly cycles after the cycle following start.
  int mult_dly = 2;
  bit mpend;
  int mcnt;
  logic [23:0] cap_a;
  logic [15:0] cap_b;
  assign mult_ready = mpend && (mcnt == 0);
  assign prod_a = 40'($signed(ma_a)) * 40'($signed(mb_a));
  assign prod_b = 40'($signed(ma_b)) * 40'($signed(mb_b));
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mpend <= 1'b0; mcnt <= 0; cap_a <= '0; cap_b <= '0;
    end else if (mstart_a) begin
      mpend <= 1'b1; mcnt <= mult_dly; cap_a <= ma_a; cap_b <= mb_a;
    end else if (mpend) begin
      if (mcnt == 0) mpend <= 1'b0;
      else mcnt <= mcnt - 1;
    end
  end

  // Filter model: returns its input two cycles later.
  bit fpend;
  int fcnt;
  assign filt_ready = fpend && (fcnt == 0);
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fpend <= 1'b0; fcnt <= 0; fout_a <= '0; fout_b <= '0;
    end else if (fstart_a) begin
      fpend <= 1'b1; fcnt <= 2; fout_a <= $signed(fin_a); fout_b <= $signed(fin_b);
    end else if (fpend) begin
      if (fcnt == 0) fpend <= 1'b0;
      else fcnt <= fcnt - 1;
    end
  end

  // Scoreboard monitor and per-cycle protocol checks.
  always @(negedge clk) begin
    int e;
    if (!rst) begin
      if (aval_a) begin
        checks++; nval_a++;
        if (qa.size() == 0) begin
          errors++; $display("FAIL audio_a: unexpected valid, got %0d", audio_a);
        end else begin
          e = qa.pop_front();
          if (int'(audio_a) != e) begin errors++; $display("FAIL audio_a: got %0d expected %0d", audio_a, e); end
        end
      end
      if (aval_b) begin
        checks++;
        if (qb.size() == 0) begin
          errors++; $display("FAIL audio_b: unexpected valid, got %0d", audio_b);
        end else begin
          e = qb.pop_front();
          if (int'(audio_b) != e) begin errors++; $display("FAIL audio_b: got %0d expected %0d", audio_b, e); end
        end
      end
      if (fstart_a) begin
        checks++;
        if (qf.size() == 0) begin
          errors++; $display("FAIL filt_in: unexpected filt_start, got %0d", $signed(fin_a));
        end else begin
          e = qf.pop_front();
          if (int'($signed(fin_a)) != e) begin errors++; $display("FAIL filt_in: got %0d expected %0d", $signed(fin_a), e); end
        end
      end
      checks++;
      if (mstart_a && (fstart_a || mpend)) begin
        errors++; $display("FAIL strobe_overlap: mstart %0b fstart %0b pending %0b", mstart_a, fstart_a, mpend);
      end
      checks++;
      if (mpend && (ma_a !== cap_a || mb_a !== cap_b)) begin
        errors++; $display("FAIL operand_hold: a %0h b %0h expected a %0h b %0h", ma_a, mb_a, cap_a, cap_b);
      end
      checks++;
      if (!mpend && !mstart_a && (ma_a != 0 || mb_a != 0)) begin
        errors++; $display("FAIL operand_idle: a %0h b %0h expected 0", ma_a, mb_a);
      end
      checks++;
      if (!fpend && !fstart_a && fin_a != 0) begin
        errors++; $display("FAIL filt_in_idle: got %0h expected 0", fin_a);
      end
      checks++;
      if (req_b !== req_a || idx_b !== idx_a || mstart_b !== mstart_a || fstart_b !== fstart_a) begin
        errors++; $display("FAIL lockstep: req %0b/%0b idx %0d/%0d", req_a, req_b, idx_a, idx_b);
      end
    end
  end

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++; $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req"}, longint'(req_a), 0);
    chk({tag, "_idx"}, longint'(idx_a), 0);
    chk({tag, "_mstart"}, longint'(mstart_a), 0);
    chk({tag, "_mult_a"}, longint'(ma_a), 0);
    chk({tag, "_mult_b"}, longint'(mb_a), 0);
    chk({tag, "_fstart"}, longint'(fstart_a), 0);
    chk({tag, "_filt_in"}, longint'(fin_a), 0);
    chk({tag, "_audio"}, longint'(audio_a), 0);
    chk({tag, "_valid"}, longint'(aval_a), 0);
    chk({tag, "_overrun"}, longint'(ovr_a), 0);
    chk({tag, "_audio_b"}, longint'(audio_b), 0);
    chk({tag, "_idx_b"}, longint'(idx_b), 0);
  endtask

  task automatic setup(input int w0, input int w1, input int w2, input int e0, input int e1,
                       input int e2, input logic [2:0] m, input logic [2:0] r, input int vol);
    w_tab[0] = 10'(w0); w_tab[1] = 10'(w1); w_tab[2] = 10'(w2); w_tab[3] = '0;
    e_tab[0] = 8'(e0);  e_tab[1] = 8'(e1);  e_tab[2] = 8'(e2);  e_tab[3] = '0;
    mute = m; route = r; volume = 8'(vol);
  endtask

  task automatic wait_valid(input int target);
    for (int i = 0; i < 400 && nval_a < target; i++) @(negedge clk);
    chk("frame_timeout", longint'(nval_a >= target), 1);
  endtask

  task automatic pulse_tick();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
  endtask

  task automatic run_frame(input int exp_a, input int exp_b, input bit has_filt, input int exp_filt);
    int target;
    qa.push_back(exp_a); qb.push_back(exp_b);
    if (has_filt) qf.push_back(exp_filt);
    target = nval_a + 1;
    pulse_tick();
    wait_valid(target);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int target;
    rst = 1'b1; tick = 1'b0;
    setup(0, 0, 0, 0, 0, 0, 3'b111, 3'b000, 0);
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // Single voice, bypass: 200*255>>>8=199; 199*128>>>8=99.
    setup(200, 0, 0, 255, 255, 255, 3'b110, 3'b000, 128);
    run_frame(99, 99, 1'b0, 0);

    // Voice 1 through filter: terms 99,-50,19; filt -50; (-50+118)*255>>>8=67.
    setup(100, -50, 20, 255, 255, 255, 3'b000, 3'b010, 255);
    run_frame(67, 67, 1'b1, -50);

    // Positive saturation: terms 509 each; ACC14 1527*255>>>8=1521, ACC10 clamps 511 -> 509.
    setup(511, 511, 511, 255, 255, 255, 3'b000, 3'b000, 255);
    run_frame(1521, 509, 1'b0, 0);
    setup(511, 511, 511, 255, 255, 255, 3'b000, 3'b111, 255);
    run_frame(1521, 509, 1'b1, 1527);

    // Negative saturation: terms -510; ACC14 -1530*255>>>8=-1525, ACC10 -512 -> -510.
    setup(-512, -512, -512, 255, 255, 255, 3'b000, 3'b000, 255);
    run_frame(-1525, -510, 1'b0, 0);

    // All muted: nothing fetched, no filter, silent sample.
    setup(300, 300, 300, 255, 255, 255, 3'b111, 3'b111, 255);
    run_frame(0, 0, 1'b0, 0);

    // Only voice 2, routed: -300*128>>>8=-150; -150*200>>>8=-118.
    setup(0, 0, -300, 0, 0, 128, 3'b011, 3'b100, 200);
    run_frame(-118, -118, 1'b1, -150);

    // Overrun: second tick while the voice multiply is outstanding.
    setup(200, 0, 0, 255, 255, 255, 3'b110, 3'b000, 128);
    qa.push_back(99); qb.push_back(99);
    target = nval_a + 1;
    pulse_tick();
    for (int i = 0; i < 100 && !mstart_a; i++) @(negedge clk);
    chk("reach_vmul", longint'(mstart_a), 1);
    tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    wait_valid(target);
    repeat (20) @(negedge clk);
    chk("one_valid_per_frame", longint'(nval_a), longint'(target));
    chk("overrun_a", longint'(ovr_a), 1);
    chk("overrun_b", longint'(ovr_b), 1);
    setup(100, -50, 20, 255, 255, 255, 3'b000, 3'b010, 255);
    run_frame(67, 67, 1'b1, -50);
    chk("overrun_sticky", longint'(ovr_a), 1);

    // Reset while a fetch is stalled, then a fresh frame.
    setup(0, 0, -300, 0, 0, 128, 3'b011, 3'b100, 200);
    ack_hold = 1'b1;
    pulse_tick();
    repeat (4) @(negedge clk);
    chk("stalled_req", longint'(req_a), 1);
    chk("stalled_idx", longint'(idx_a), 2);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("midframe_reset");
    @(negedge clk);
    rst = 1'b0; ack_hold = 1'b0;
    repeat (8) @(negedge clk);
    chk("no_frame_without_tick", longint'(aval_a), 0);
    run_frame(-118, -118, 1'b1, -150);

    // Multiplier latency 0 and 7 with random voice latency: same results.
    ack_rand = 1'b1;
    setup(100, -50, 20, 255, 255, 255, 3'b000, 3'b010, 255);
    mult_dly = 0;
    run_frame(67, 67, 1'b1, -50);
    mult_dly = 7;
    run_frame(67, 67, 1'b1, -50);
    setup(511, 511, 511, 255, 255, 255, 3'b000, 3'b000, 255);
    run_frame(1521, 509, 1'b0, 0);

    repeat (10) @(negedge clk);
    chk("queue_a_drained", longint'(qa.size()), 0);
    chk("queue_b_drained", longint'(qb.size()), 0);
    chk("queue_f_drained", longint'(qf.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
